// File: rtl/halut_decoder_ctrl.sv
// Sequencer for one halut_decoder: streams the LUT into the decoder, then issues
// per-codebook k-indices row by row and buffers FP32 row results (2 deep, credit-gated).
module halut_decoder_ctrl #(
    parameter int unsigned K              = 16,
    parameter int unsigned C              = 32,
    parameter int unsigned DataTypeWidth  = 16,
    parameter int unsigned RowCntWidth    = 16,
    parameter int unsigned TotalAddrWidth = $clog2(C*K),
    parameter int unsigned CAddrWidth     = $clog2(C),
    parameter int unsigned TreeDepth      = $clog2(K)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic                      load_lut_i,
    input  logic [RowCntWidth-1:0]    rows_i,
    input  logic                      lut_valid_i,
    input  logic [DataTypeWidth-1:0]  lut_data_i,
    output logic                      lut_ready_o,
    input  logic                      enc_valid_i,
    input  logic [TreeDepth-1:0]      enc_k_i,
    output logic                      enc_ready_o,
    output logic                      res_valid_o,
    output logic [31:0]               res_data_o,
    input  logic                      res_ready_i,
    output logic                      busy_o,
    output logic [TotalAddrWidth-1:0] dec_waddr_o,
    output logic [DataTypeWidth-1:0]  dec_wdata_o,
    output logic                      dec_we_o,
    output logic [CAddrWidth-1:0]     dec_c_addr_o,
    output logic [TreeDepth-1:0]      dec_k_addr_o,
    output logic                      dec_decoder_o,
    input  logic [31:0]               dec_result_i,
    input  logic                      dec_valid_i
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]                r_state;
    logic [1:0]                w_state_nxt;
    logic [TotalAddrWidth-1:0] r_wcnt;
    logic [CAddrWidth-1:0]     r_ccnt;
    logic [RowCntWidth-1:0]    r_rowcnt;
    logic [RowCntWidth-1:0]    r_rows;
    logic [1:0]                r_inflight;
    logic [1:0]                r_occ;
    logic                      r_rd_ptr;
    logic                      r_wr_ptr;
    logic [31:0]               r_buf [2];

    logic w_start;
    logic w_lut_hs;
    logic w_lut_last;
    logic w_enc_hs;
    logic w_row_end;
    logic w_row_last;
    logic w_credit_ok;
    logic w_push;
    logic w_pop;

    assign w_start     = (r_state == S_IDLE) && start_i;
    assign lut_ready_o = (r_state == S_LOAD);
    assign w_lut_hs    = lut_valid_i && lut_ready_o;
    assign w_lut_last  = &r_wcnt;

    // A new row may only start if its result has a guaranteed buffer slot;
    // a row already under way is always allowed to finish.
    assign w_credit_ok = ({1'b0, r_occ} + {1'b0, r_inflight}) < 3'd2;
    assign enc_ready_o = (r_state == S_RUN) && ((r_ccnt != '0) || w_credit_ok);
    assign w_enc_hs    = enc_valid_i && enc_ready_o;
    assign w_row_end   = w_enc_hs && (&r_ccnt);
    assign w_row_last  = (r_rowcnt == (r_rows - RowCntWidth'(1)));

    assign w_push      = dec_valid_i && (r_inflight != 2'd0);
    assign res_valid_o = (r_occ != 2'd0);
    assign res_data_o  = r_buf[r_rd_ptr];
    assign w_pop       = res_valid_o && res_ready_i;
    assign busy_o      = (r_state != S_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    if (load_lut_i)
                        w_state_nxt = S_LOAD;
                    else if (rows_i != '0)
                        w_state_nxt = S_RUN;
                end
            end
            S_LOAD: begin
                if (w_lut_hs && w_lut_last)
                    w_state_nxt = (r_rows != '0) ? S_RUN : S_IDLE;
            end
            S_RUN: begin
                if (w_row_end && w_row_last)
                    w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if ((r_inflight == 2'd0) && (r_occ == 2'd0))
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rows   <= '0;
            r_rowcnt <= '0;
        end else if (w_start) begin
            r_rows   <= rows_i;
            r_rowcnt <= '0;
        end else if (w_row_end) begin
            r_rowcnt <= r_rowcnt + RowCntWidth'(1);
        end
    end

    // Both counters wrap to zero naturally at their last value (C, K powers of 2).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wcnt <= '0;
            r_ccnt <= '0;
        end else begin
            if (w_start)
                r_wcnt <= '0;
            else if (w_lut_hs)
                r_wcnt <= r_wcnt + TotalAddrWidth'(1);
            if (w_start)
                r_ccnt <= '0;
            else if (w_enc_hs)
                r_ccnt <= r_ccnt + CAddrWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dec_we_o      <= 1'b0;
            dec_waddr_o   <= '0;
            dec_wdata_o   <= '0;
            dec_decoder_o <= 1'b0;
            dec_c_addr_o  <= '0;
            dec_k_addr_o  <= '0;
        end else begin
            dec_we_o      <= w_lut_hs;
            dec_waddr_o   <= w_lut_hs ? r_wcnt : '0;
            dec_wdata_o   <= w_lut_hs ? lut_data_i : '0;
            dec_decoder_o <= w_enc_hs;
            dec_c_addr_o  <= w_enc_hs ? r_ccnt : '0;
            dec_k_addr_o  <= w_enc_hs ? enc_k_i : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_inflight <= 2'd0;
        else
            r_inflight <= r_inflight + {1'b0, w_row_end} - {1'b0, w_push};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_buf[0] <= '0;
            r_buf[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_push) begin
                r_buf[r_wr_ptr] <= dec_result_i;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: tb/tb_halut_decoder_ctrl.sv
// Scoreboard bench for halut_decoder_ctrl with a behavioural integer-valued decoder
// model; expected FP32 row results are hand-computed constants queued at stimulus time.
module tb_halut_decoder_ctrl;
    localparam int unsigned K  = 16;
    localparam int unsigned C  = 32;
    localparam int unsigned DW = 16;
    localparam int unsigned RW = 16;
    localparam int unsigned AW = $clog2(C*K);
    localparam int unsigned CW = $clog2(C);
    localparam int unsigned TD = $clog2(K);

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          start_i, load_lut_i;
    logic [RW-1:0] rows_i;
    logic          lut_valid_i;
    logic [DW-1:0] lut_data_i;
    logic          lut_ready_o;
    logic          enc_valid_i;
    logic [TD-1:0] enc_k_i;
    logic          enc_ready_o;
    logic          res_valid_o;
    logic [31:0]   res_data_o;
    logic          res_ready_i;
    logic          busy_o;
    logic [AW-1:0] dec_waddr_o;
    logic [DW-1:0] dec_wdata_o;
    logic          dec_we_o;
    logic [CW-1:0] dec_c_addr_o;
    logic [TD-1:0] dec_k_addr_o;
    logic          dec_decoder_o;
    logic [31:0]   dec_result_i;
    logic          dec_valid_i;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] sb_q[$];

    logic r_hold = 1'b1;
    logic r_rand = 1'b1;
    logic rnd_on = 1'b0;
    assign res_ready_i = rnd_on ? r_rand : r_hold;

    always #5 clk = ~clk;

    halut_decoder_ctrl #(
        .K(K), .C(C), .DataTypeWidth(DW), .RowCntWidth(RW),
        .TotalAddrWidth(AW), .CAddrWidth(CW), .TreeDepth(TD)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .load_lut_i(load_lut_i),
        .rows_i(rows_i), .lut_valid_i(lut_valid_i), .lut_data_i(lut_data_i),
        .lut_ready_o(lut_ready_o), .enc_valid_i(enc_valid_i), .enc_k_i(enc_k_i),
        .enc_ready_o(enc_ready_o), .res_valid_o(res_valid_o), .res_data_o(res_data_o),
        .res_ready_i(res_ready_i), .busy_o(busy_o), .dec_waddr_o(dec_waddr_o),
        .dec_wdata_o(dec_wdata_o), .dec_we_o(dec_we_o), .dec_c_addr_o(dec_c_addr_o),
        .dec_k_addr_o(dec_k_addr_o), .dec_decoder_o(dec_decoder_o),
        .dec_result_i(dec_result_i), .dec_valid_i(dec_valid_i)
    );

    function automatic logic [15:0] int2f16(input int n);
        int e;
        if (n == 0) return 16'h0000;
        e = 0;
        for (int b = 0; b < 16; b++) if (n >= (1 << b)) e = b;
        return {1'b0, 5'(15 + e), 10'((n - (1 << e)) << (10 - e))};
    endfunction

    function automatic int f16toint(input logic [15:0] h);
        int e;
        if (h == 16'h0000) return 0;
        e = int'(h[14:10]) - 15;
        return int'({1'b1, h[9:0]}) >> (10 - e);
    endfunction

    function automatic logic [31:0] int2f32(input int n);
        int e;
        if (n == 0) return 32'h0;
        e = 0;
        for (int b = 0; b < 24; b++) if (n >= (1 << b)) e = b;
        return {1'b0, 8'(127 + e), 23'((n - (1 << e)) << (23 - e))};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural decoder: one-cycle registered result at the end of each row.
    logic [15:0] m_lut [C*K];
    int          m_acc;
    always @(posedge clk or negedge rst_ni) begin
        int sum;
        if (!rst_ni) begin
            m_acc        <= 0;
            dec_valid_i  <= 1'b0;
            dec_result_i <= '0;
        end else begin
            dec_valid_i <= 1'b0;
            if (dec_we_o) m_lut[dec_waddr_o] <= dec_wdata_o;
            if (dec_decoder_o) begin
                sum = m_acc + f16toint(m_lut[{dec_c_addr_o, dec_k_addr_o}]);
                if (dec_c_addr_o == CW'(C - 1)) begin
                    dec_result_i <= int2f32(sum);
                    dec_valid_i  <= 1'b1;
                    m_acc        <= 0;
                end else begin
                    m_acc <= sum;
                end
            end
        end
    end

    int          wr_cnt = 0;
    int          wr_err = 0;
    int          inv_err = 0;
    logic [AW-1:0] exp_waddr = '0;
    always @(negedge clk) begin
        #1;
        if (dec_we_o) begin
            if (dec_waddr_o != exp_waddr) wr_err++;
            exp_waddr = exp_waddr + AW'(1);
            wr_cnt++;
        end
        if (!dec_decoder_o && (dec_c_addr_o != '0 || dec_k_addr_o != '0)) inv_err++;
        if (rst_ni && res_valid_o && res_ready_i) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got %0h expected none", res_data_o);
            end else begin
                check("row_result", res_data_o, sb_q.pop_front());
            end
        end
    end

    always @(negedge clk) r_rand <= 1'($urandom_range(0, 1));

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic do_start(input int rows, input logic load);
        @(negedge clk);
        start_i = 1'b1; rows_i = RW'(rows); load_lut_i = load;
        @(negedge clk);
        start_i = 1'b0; rows_i = '0; load_lut_i = 1'b0;
    endtask

    task automatic send_lut(input logic [15:0] d);
        logic hs = 1'b0;
        lut_valid_i = 1'b1; lut_data_i = d;
        for (int t = 0; t < 200 && !hs; t++) begin
            hs = lut_ready_o;
            @(negedge clk);
        end
        lut_valid_i = 1'b0;
        if (!hs) check("lut_timeout", 32'(hs), 32'd1);
    endtask

    task automatic send_enc(input int k, input int gap);
        logic hs = 1'b0;
        repeat (gap) @(negedge clk);
        enc_valid_i = 1'b1; enc_k_i = TD'(k);
        for (int t = 0; t < 400 && !hs; t++) begin
            hs = enc_ready_o;
            @(negedge clk);
        end
        enc_valid_i = 1'b0;
        if (!hs) check("enc_timeout", 32'(hs), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        for (int t = 0; t < 500 && busy_o; t++) @(negedge clk);
        check(name, 32'(busy_o), 32'd0);
        check({name, "_sb_drained"}, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, 32'({busy_o, res_valid_o, enc_ready_o, lut_ready_o,
                                   dec_we_o, dec_decoder_o}), 32'd0);
        check({name, "_res"}, res_data_o, 32'd0);
        check({name, "_dec"}, 32'({dec_waddr_o, dec_c_addr_o, dec_k_addr_o}), 32'd0);
        check({name, "_wdata"}, 32'(dec_wdata_o), 32'd0);
    endtask

    initial begin
        rst_ni = 1'b0; start_i = 1'b0; load_lut_i = 1'b0; rows_i = '0;
        lut_valid_i = 1'b0; lut_data_i = '0; enc_valid_i = 1'b0; enc_k_i = '0;
        repeat (3) @(negedge clk);
        #1 check_all_zero("reset");
        @(negedge clk) rst_ni = 1'b1;

        // Test 1: LUT all 1.0, one row of k=3 -> 32.0
        do_start(1, 1'b1);
        check("busy_after_start", 32'(busy_o), 32'd1);
        for (int i = 0; i < C*K; i++) send_lut(16'h3C00);
        repeat (2) @(negedge clk);
        check("wr_count_t1", 32'(wr_cnt), 32'(C*K));
        check("wr_addr_err_t1", 32'(wr_err), 32'd0);
        sb_q.push_back(32'h4200_0000);
        for (int c = 0; c < C; c++) send_enc(3, 0);
        wait_idle("idle_t1");

        // Test 2: load-only job (rows=0), then rows=2 without load
        wr_cnt = 0;
        do_start(0, 1'b1);
        for (int i = 0; i < C*K; i++) send_lut(int2f16(i % K));
        repeat (2) @(negedge clk);
        check("wr_count_t2", 32'(wr_cnt), 32'(C*K));
        check("wr_addr_err_t2", 32'(wr_err), 32'd0);
        check("idle_after_load_only", 32'(busy_o), 32'd0);
        do_start(2, 1'b0);
        check("lut_ready_in_run", 32'(lut_ready_o), 32'd0);
        sb_q.push_back(32'h4200_0000);
        sb_q.push_back(32'h4280_0000);
        for (int c = 0; c < C; c++) send_enc(1, 0);
        for (int c = 0; c < C; c++) send_enc(2, 0);
        wait_idle("idle_t2");

        // Test 3: backpressure, rows=4 with k=row+1
        r_hold = 1'b0;
        do_start(4, 1'b0);
        sb_q.push_back(32'h4200_0000);
        sb_q.push_back(32'h4280_0000);
        sb_q.push_back(32'h42C0_0000);
        sb_q.push_back(32'h4300_0000);
        for (int c = 0; c < C; c++) send_enc(1, 0);
        for (int c = 0; c < C; c++) send_enc(2, 0);
        repeat (20) @(negedge clk);
        check("bp_enc_ready_low", 32'(enc_ready_o), 32'd0);
        check("bp_res_valid", 32'(res_valid_o), 32'd1);
        check("bp_head_stable", res_data_o, 32'h4200_0000);
        r_hold = 1'b1;
        for (int c = 0; c < C; c++) send_enc(3, 0);
        for (int c = 0; c < C; c++) send_enc(4, 0);
        wait_idle("idle_t3");

        // Test 4: random enc gaps and random res_ready, k = c % 16 -> 240.0
        rnd_on = 1'b1;
        do_start(2, 1'b0);
        sb_q.push_back(32'h4370_0000);
        sb_q.push_back(32'h4370_0000);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < C; c++) send_enc(c % K, int'($urandom_range(0, 3)));
        wait_idle("idle_t4");
        rnd_on = 1'b0;

        // Test 5: empty job without load stays idle
        do_start(0, 1'b0);
        repeat (5) @(negedge clk);
        check("empty_job_busy", 32'(busy_o), 32'd0);
        check("empty_job_valid", 32'(res_valid_o), 32'd0);
        check("empty_job_enc_ready", 32'(enc_ready_o), 32'd0);

        // Test 6: reset mid-row, then a clean job (k=3 -> 96.0)
        do_start(1, 1'b0);
        for (int c = 0; c < 10; c++) send_enc(5, 0);
        enc_valid_i = 1'b1; enc_k_i = TD'(5);
        rst_ni = 1'b0;
        #1 check_all_zero("midrow_reset");
        enc_valid_i = 1'b0;
        @(negedge clk) rst_ni = 1'b1;
        do_start(1, 1'b0);
        sb_q.push_back(32'h42C0_0000);
        for (int c = 0; c < C; c++) send_enc(3, 0);
        wait_idle("idle_t6");

        repeat (3) @(negedge clk);
        check("invariant_c_k_zero", 32'(inv_err), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
